mult_unit_param: RTL

Parametrised sequential two's-complement multiplier. Multiplies a WIDTH-bit multiplicand by a WIDTH-bit multiplier with one add-or-subtract-then-arithmetic-shift step per cycle, and returns a 2*WIDTH-bit signed product. The block carries its own control FSM and a Start/Busy/Done handshake, so no external sequencer is needed. It sits in the datapath wherever a signed multiply can tolerate WIDTH+1 cycles of latency.

---
 rtl/mult_unit_param_if.sv | 18 +
 rtl/mult_unit_param.sv | 58 +++++
 2 files changed

// File: rtl/mult_unit_param_if.sv
// mult_unit_param_if: Start/Busy/Done handshake and operand/result bus for mult_unit_param.
// The ovf signal exists only when MULT_OVF_FLAG_EN is defined.
interface mult_unit_param_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] m;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
`ifdef MULT_OVF_FLAG_EN
  logic ovf;
  modport master(output start, s, m, input busy, done, product, ovf);
  modport slave(input start, s, m, output busy, done, product, ovf);
`else
  modport master(output start, s, m, input busy, done, product);
  modport slave(input start, s, m, output busy, done, product);
`endif
endinterface

// File: rtl/mult_unit_param.sv
// mult_unit_param: sequential signed add/shift multiplier, WIDTH+1 cycle latency.
// Optional overflow flag enabled by MULT_OVF_FLAG_EN.
module mult_unit_param #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst_n,
  mult_unit_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sreg, b;
  logic [WIDTH:0] xa, sx, t;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] product, p_nx;
  logic last;
  // The last multiplier bit carries negative weight, hence subtract on the final step.
  always_comb begin
    last = cnt == CW'(WIDTH - 1);
    sx = {sreg[WIDTH-1], sreg};
    t = !b[0] ? xa : last ? xa - sx : xa + sx;
    p_nx = {t[WIDTH:1], t[0], b[WIDTH-1:1]};
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg <= '0;
      b <= '0;
      xa <= '0;
      cnt <= '0;
      product <= '0;
    end else if (state == IDLE && bus.start) begin
      sreg <= bus.s;
      b <= bus.m;
      xa <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      xa <= {t[WIDTH], t[WIDTH:1]};
      b <= {t[0], b[WIDTH-1:1]};
      cnt <= last ? cnt : cnt + CW'(1);
      if (last) product <= p_nx;
    end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.product = product;
`ifdef MULT_OVF_FLAG_EN
  logic ovf;
  // Product fits in WIDTH signed bits only when its top WIDTH+1 bits are all equal.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= !(&p_nx[2*WIDTH-1:WIDTH-1] || ~|p_nx[2*WIDTH-1:WIDTH-1]);
  assign bus.ovf = ovf;
`endif
endmodule
